device_interface: RTL and testbench

- Bus-side register file shared by memory-mapped peripherals (e.g. LED PWM device).
- The CPU bus writes or reads one of 32 byte-wide registers, selected by address, enable and mode.
- Every register is continuously exported in parallel as device_data for the owning peripheral's logic.

---
 rtl/dev_pkg.sv | 14 +
 rtl/device_interface_if.sv | 29 ++
 rtl/device_interface.sv | 43 ++++
 tb/tb_device_interface.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dev_pkg.sv
// Shared types and constants for the bus-side device register file.
package dev_pkg;

    localparam int unsigned DEV_ADDR_W = 5;
    localparam int unsigned DEV_DATA_W = 8;
    localparam int unsigned DEV_DEPTH  = 2 ** DEV_ADDR_W;

    typedef logic [DEV_DATA_W-1:0] dev_byte_t;
    typedef logic [DEV_ADDR_W-1:0] dev_addr_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/device_interface_if.sv
// CPU-side register access bus: address/enable/mode/data_in in, data_out back.
interface device_interface_if;
    import dev_pkg::*;

    dev_addr_t address;
    logic      enable;
    logic      mode;
    dev_byte_t data_in;
    dev_byte_t data_out;

    // CPU / bus initiator side
    modport master (
        output address,
        output enable,
        output mode,
        output data_in,
        input  data_out
    );

    // Register file side
    modport slave (
        input  address,
        input  enable,
        input  mode,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/device_interface.sv
// 32 x 8-bit register file written/read by the CPU bus and exported in
// parallel to the owning peripheral.
module device_interface
    import dev_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    device_interface_if.slave     bus,
    output dev_byte_t             device_data [DEV_DEPTH-1:0]
);

    dev_byte_t regs_q [DEV_DEPTH-1:0];
    dev_byte_t regs_d [DEV_DEPTH-1:0];

    // Next-state: only an enabled write touches a single register.
    always_comb begin
        regs_d = regs_q;
        if (bus.enable && (bus.mode == MODE_WRITE)) begin
            regs_d[bus.address] = bus.data_in;
        end
    end

    // Register array with asynchronous clear; a write racing reset is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Zero-latency read mux; bus returns 0 unless an enabled read is in progress.
    always_comb begin
        bus.data_out = '0;
        if (bus.enable && (bus.mode == MODE_READ)) begin
            bus.data_out = regs_q[bus.address];
        end
    end

    // Peripheral sees every register live, independent of bus activity.
    assign device_data = regs_q;

endmodule

// File: tb/tb_device_interface.sv
// Self-checking bench for device_interface: directed scenarios plus a
// randomized access mix checked against a simple array model.
module tb_device_interface;
    import dev_pkg::*;

    logic      clk;
    logic      rst_n;
    dev_byte_t device_data [DEV_DEPTH-1:0];

    device_interface_if bus ();

    device_interface dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .device_data (device_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    dev_byte_t   model [DEV_DEPTH];

    task automatic model_clear();
        for (int i = 0; i < DEV_DEPTH; i++) model[i] = 8'h00;
    endtask

    task automatic bus_idle();
        bus.enable  = 1'b0;
        bus.mode    = MODE_READ;
        bus.address = '0;
        bus.data_in = '0;
    endtask

    // One write cycle: inputs set at negedge, committed at posedge.
    task automatic do_write(input dev_addr_t a, input dev_byte_t d);
        @(negedge clk);
        bus.address = a;
        bus.enable  = 1'b1;
        bus.mode    = MODE_WRITE;
        bus.data_in = d;
        @(posedge clk);
        model[a] = d;
        #1;
        bus.enable = 1'b0;
    endtask

    task automatic check_read(input string name, input dev_addr_t a, input dev_byte_t exp);
        bus.address = a;
        bus.enable  = 1'b1;
        bus.mode    = MODE_READ;
        #1;
        n_vec++;
        if (bus.data_out !== exp) begin
            n_err++;
            $display("FAIL %s: read addr %0d got %h expected %h", name, a, bus.data_out, exp);
        end
        bus.enable = 1'b0;
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < DEV_DEPTH; i++) begin
            n_vec++;
            if (device_data[i] !== model[i]) begin
                n_err++;
                $display("FAIL %s: device_data[%0d] got %h expected %h",
                         name, i, device_data[i], model[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_write(5'd5, 8'h77);
        do_write(5'd20, 8'h9E);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all("reset_clear");
        check_read("reset_read5", 5'd5, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_readback();
        do_write(5'd3, 8'hA5);
        check_all("wr_device_data");
        @(negedge clk);
        check_read("wr_readback3", 5'd3, 8'hA5);
    endtask

    task automatic test_sweep();
        for (int a = 0; a < DEV_DEPTH; a++) do_write(dev_addr_t'(a), dev_byte_t'(a * 7 + 1));
        @(negedge clk);
        for (int a = 0; a < DEV_DEPTH; a++)
            check_read("sweep_read", dev_addr_t'(a), dev_byte_t'(a * 7 + 1));
        check_all("sweep_device_data");
    endtask

    task automatic test_gating();
        @(negedge clk);
        bus.address = 5'd10;
        bus.enable  = 1'b0;
        bus.mode    = MODE_WRITE;
        bus.data_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (bus.data_out !== 8'h00) begin
                n_err++;
                $display("FAIL gate_dout: got %h expected 00", bus.data_out);
            end
            n_vec++;
            if (device_data[10] !== model[10]) begin
                n_err++;
                $display("FAIL gate_reg10: got %h expected %h", device_data[10], model[10]);
            end
        end
        @(negedge clk);
        bus.enable = 1'b1;
        #1;
        n_vec++;
        if (bus.data_out !== 8'h00) begin
            n_err++;
            $display("FAIL write_dout: got %h expected 00", bus.data_out);
        end
        @(posedge clk);
        model[10] = 8'hFF;
        #1;
        bus.enable = 1'b0;
        check_all("gate_after_write");
    endtask

    task automatic test_overwrite();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        rst_n = 1'b1;
        do_write(5'd31, 8'h11);
        do_write(5'd31, 8'h22);
        @(negedge clk);
        check_read("ovw_read31", 5'd31, 8'h22);
        check_read("ovw_read30", 5'd30, 8'h00);
        check_read("ovw_read0", 5'd0, 8'h00);
    endtask

    task automatic test_async_reset();
        do_write(5'd7, 8'h5A);
        // Reset between edges, with a write pending: write must be lost.
        @(negedge clk);
        bus.address = 5'd0;
        bus.enable  = 1'b1;
        bus.mode    = MODE_WRITE;
        bus.data_in = 8'hEE;
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all("async_clear");
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        check_all("reset_mid_write");
        @(negedge clk);
        rst_n = 1'b1;
        do_write(5'd0, 8'h3C);
        @(negedge clk);
        check_read("post_reset_read0", 5'd0, 8'h3C);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int unsigned op;
            dev_addr_t   a;
            dev_byte_t   d;
            op = $urandom_range(0, 2);
            a  = dev_addr_t'($urandom);
            d  = dev_byte_t'($urandom);
            if (op == 0) begin
                do_write(a, d);
            end else if (op == 1) begin
                @(negedge clk);
                check_read("rand_read", a, model[a]);
            end else begin
                @(negedge clk);
                bus.address = a;
                bus.enable  = 1'b0;
                bus.mode    = logic'($urandom_range(0, 1));
                bus.data_in = d;
                @(posedge clk);
                #1;
                n_vec++;
                if (bus.data_out !== 8'h00) begin
                    n_err++;
                    $display("FAIL rand_idle_dout: got %h expected 00", bus.data_out);
                end
            end
            n_vec++;
            if (device_data[a] !== model[a]) begin
                n_err++;
                $display("FAIL rand_device_data: addr %0d got %h expected %h",
                         a, device_data[a], model[a]);
            end
        end
        check_all("rand_final");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_clear();
        bus_idle();
        rst_n = 1'b0;
        #12;
        check_all("initial_reset");
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write_readback();
        test_sweep();
        test_gating();
        test_overwrite();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
